// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI4 INCR-burst slave backed by an internal 32-bit word RAM
module axi_ram_slave #(
    parameter int ADDR_W     = 24,
    parameter int MEM_ADDR_W = 14,
    parameter int ID_W       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [DEPTH];

    // Byte-lane bits and address bits above the RAM are ignored, so the RAM aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_awaddr[ADDR_W-1:MEM_ADDR_W+2],
                                s_axi_araddr[1:0], s_axi_araddr[ADDR_W-1:MEM_ADDR_W+2]};

    // ---------------- write channel ----------------
    w_state_t              w_state_q, w_state_d;
    logic [ID_W-1:0]       awid_q, awid_d;
    logic [MEM_ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;

    // Write FSM next state; ready/valid outputs are registered from the next state.
    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    awid_d    = s_axi_awid;
                    waddr_d   = s_axi_awaddr[MEM_ADDR_W+1:2];
                    wcnt_d    = s_axi_awlen;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    mem_we  = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    if (s_axi_wlast != (wcnt_q == 8'd0)) begin
                        werr_d = 1'b1;
                    end
                    // The beat count alone terminates the burst; wlast only flags errors.
                    if (wcnt_q == 8'd0) begin
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q - 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = (w_state_d == W_RESP && werr_d) ? 2'b10 : 2'b00;
    end

    // Write channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // RAM byte-enabled write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[waddr_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = awid_q;

    // ---------------- read channel ----------------
    r_state_t              r_state_q, r_state_d;
    logic [ID_W-1:0]       arid_q, arid_d;
    logic [MEM_ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            fcnt_q, fcnt_d;
    logic                  fdone_q, fdone_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  r_accept;

    assign r_accept = rvalid_q && s_axi_rready;

    // Read FSM: the output register is refilled from RAM whenever it is empty or being drained,
    // which gives one beat per cycle under rready=1 and holds the beat stable while stalled.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        fcnt_d    = fcnt_q;
        fdone_d   = fdone_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    arid_d    = s_axi_arid;
                    raddr_d   = s_axi_araddr[MEM_ADDR_W+1:2];
                    rlen_d    = s_axi_arlen;
                    fcnt_d    = 8'd0;
                    fdone_d   = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_accept && rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else if ((!rvalid_q || s_axi_rready) && !fdone_q) begin
                    rdata_d  = mem[raddr_q];
                    rvalid_d = 1'b1;
                    rlast_d  = (fcnt_q == rlen_q);
                    fdone_d  = (fcnt_q == rlen_q);
                    raddr_d  = raddr_q + 1'b1;
                    fcnt_d   = fcnt_q + 8'd1;
                end else if (r_accept) begin
                    rvalid_d = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Read channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            fcnt_q    <= '0;
            fdone_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            fcnt_q    <= fcnt_d;
            fdone_q   <= fdone_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rid     = arid_q;
    assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed and randomized bench for axi_ram_slave with a RAM model
module tb_axi_ram_slave;

    localparam int DEPTH = 1 << 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  s_axi_awid = '0;
    logic [23:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [0:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [0:0]  s_axi_arid = '0;
    logic [23:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [0:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    axi_ram_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem   [DEPTH];
    logic [3:0]  ref_known [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Burst write using wd/ws; err_beat >= 0 moves wlast onto that beat instead of the last one.
    task automatic axi_write(input logic [23:0] addr, input int len, input int err_beat,
                             input logic id, output logic [1:0] resp);
        logic [13:0] word;
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin tick(); n++; end
        check("aw_ready", 32'(s_axi_awready), 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
        word = addr[15:2];
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wvalid = 1'b1;
            s_axi_wlast = (err_beat >= 0) ? (i == err_beat) : (i == len);
            n = 0;
            while (!s_axi_wready && n < 50) begin tick(); n++; end
            check("w_ready", 32'(s_axi_wready), 32'd1);
            tick();
            for (int b = 0; b < 4; b++) begin
                if (ws[i][b]) begin
                    ref_mem[word][8*b +: 8] = wd[i][8*b +: 8];
                    ref_known[word][b] = 1'b1;
                end
            end
            word = word + 14'd1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check("w_beats_end", 32'(s_axi_wready), 32'd0);
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin tick(); n++; end
        check("b_valid", 32'(s_axi_bvalid), 32'd1);
        check("b_id", 32'(s_axi_bid), 32'(id));
        resp = s_axi_bresp;
        tick();
        s_axi_bready = 1'b0;
        check("b_done", 32'(s_axi_bvalid), 32'd0);
    endtask

    // Burst read; mode 0 = rready always, 1 = one cycle in three, 2 = random.
    task automatic axi_read(input logic [23:0] addr, input int len, input logic id, input int mode);
        logic [13:0] word;
        logic [31:0] mask, prev_data;
        logic        prev_last, stalled, acc, rdy;
        int n, beat, cyc;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        check("ar_ready", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        check("r_lat_first", 32'(s_axi_rvalid), 32'd0);
        tick();
        check("r_lat_second", 32'(s_axi_rvalid), 32'd1);
        word = addr[15:2]; beat = 0; cyc = 0; stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (beat <= len && cyc < 3000) begin
            if (s_axi_rvalid) begin
                if (stalled) begin
                    check("r_stall_data", s_axi_rdata, prev_data);
                    check("r_stall_last", 32'(s_axi_rlast), 32'(prev_last));
                end
                mask = {{8{ref_known[word][3]}}, {8{ref_known[word][2]}},
                        {8{ref_known[word][1]}}, {8{ref_known[word][0]}}};
                check("r_data", s_axi_rdata & mask, ref_mem[word] & mask);
                check("r_last", 32'(s_axi_rlast), 32'(beat == len));
                check("r_id", 32'(s_axi_rid), 32'(id));
                check("r_resp", 32'(s_axi_rresp), 32'd0);
            end else if (mode == 0) begin
                check("r_gapless", 32'(s_axi_rvalid), 32'd1);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            s_axi_rready = rdy;
            acc = s_axi_rvalid && rdy;
            stalled = s_axi_rvalid && !rdy;
            prev_data = s_axi_rdata; prev_last = s_axi_rlast;
            tick();
            cyc++;
            if (acc) begin beat++; word = word + 14'd1; end
        end
        s_axi_rready = 1'b0;
        check("r_beats", 32'(beat), 32'(len + 1));
        check("r_end", 32'(s_axi_rvalid), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [23:0] a;
        int len, n;
        logic id;

        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 4'h0; end

        tick(); tick();
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_outs", {s_axi_rdata}, 32'd0);
        check("rst_misc", {26'd0, s_axi_bresp, s_axi_rresp, s_axi_rlast, s_axi_bid ^ s_axi_rid}, 32'd0);
        check("rst_ids", {30'd0, s_axi_bid, s_axi_rid}, 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_arready", 32'(s_axi_arready), 32'd1);
        check("post_rst_awready", 32'(s_axi_awready), 32'd1);

        // single word
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(24'h000010, 0, -1, 1'b0, resp);
        check("single_bresp", 32'(resp), 32'd0);
        axi_read(24'h000010, 0, 1'b1, 0);

        // 16-beat burst, data = beat index
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        axi_write(24'h000100, 15, -1, 1'b1, resp);
        check("burst16_bresp", 32'(resp), 32'd0);
        axi_read(24'h000100, 15, 1'b0, 0);

        // partial strobe merge
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(24'h000080, 0, -1, 1'b0, resp);
        wd[0] = 32'h12345678; ws[0] = 4'h3;
        axi_write(24'h000080, 0, -1, 1'b0, resp);
        axi_read(24'h000080, 0, 1'b0, 0);

        // 8-beat read with sparse rready
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(24'h000400, 7, -1, 1'b1, resp);
        axi_read(24'h000400, 7, 1'b1, 1);

        // wrap at the top of the RAM
        wd[0] = 32'hA5A5_0001; wd[1] = 32'h5A5A_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(24'h00FFFC, 1, -1, 1'b0, resp);
        axi_read(24'h000000, 0, 1'b0, 0);
        axi_read(24'h00FFFC, 1, 1'b1, 0);

        // misplaced wlast: beat count still ends the burst, SLVERR reported
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(24'h000200, 3, 1, 1'b1, resp);
        check("wlast_err_bresp", 32'(resp), 32'd2);
        axi_read(24'h000200, 3, 1'b0, 0);

        // reset during a read burst
        s_axi_arid = 1'b0; s_axi_araddr = 24'h000100; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        tick();
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin tick(); n++; end
        check("midrst_rvalid_before", 32'(s_axi_rvalid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("midrst_arready", 32'(s_axi_arready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_arready_after", 32'(s_axi_arready), 32'd1);
        check("midrst_awready_after", 32'(s_axi_awready), 32'd1);
        axi_read(24'h000104, 2, 1'b1, 2);

        // randomized bursts with aliased upper address bits
        for (int t = 0; t < 20; t++) begin
            a = 24'($urandom);
            len = $urandom_range(0, 7);
            id = 1'($urandom_range(0, 1));
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(a, len, -1, id, resp);
            check("rand_bresp", 32'(resp), 32'd0);
            axi_read({8'($urandom), a[15:0]}, len, ~id, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
